// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM-stage data port. It accepts one load or store at a
// time, holds the pipeline for WAIT_STATES cycles, then returns a single-cycle response.
// Faulting requests (out of range or misaligned) produce rsp_err and have no side effect.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        op_we;
  logic [31:0] op_addr;
  logic [3:0]  op_be;
  logic [31:0] op_wdata;
  logic [AW-1:0] op_idx;
  logic        op_oob;
  logic        op_misalign;
  logic        op_fault;

  // The request being executed: live fields while idle (needed when WAIT_STATES is 0 and
  // the accept edge is also the commit edge), latched fields otherwise.
  always_comb begin
    if (state_q == StIdle) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_be    = req_be;
      op_wdata = req_wdata;
    end else begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_be    = be_q;
      op_wdata = wdata_q;
    end
    op_idx      = op_addr[AW+1:2];
    op_oob      = (op_addr >> (AW + 2)) != 32'd0;
    op_misalign = ((op_be == 4'hF) && (op_addr[1:0] != 2'b00)) ||
                  (((op_be == 4'h3) || (op_be == 4'hC)) && op_addr[0]) ||
                  (op_be == 4'h0);
    op_fault    = op_oob || op_misalign;
  end

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    enter_resp = (state_d == StResp) && (state_q != StResp);
  end

  // Control state, latched request and response registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= op_fault;
        rdata_q <= (op_fault || op_we) ? 32'd0 : mem[op_idx];
      end else if (state_q == StResp) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Byte-lane store commit on the edge entering RESP; reset blocks a pending store.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && op_we && !op_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) begin
          mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // Gated by reset so the pipeline is never held while the responder is being cleared.
  assign stall     = rst & (((state_q == StIdle) & req_valid) | (state_q == StWait));

endmodule
